// File: rtl/group_add_ctrl_pkg.sv
// Shared constants and helpers for the group_add summing pipeline and its
// flow-control wrapper.
package group_add_ctrl_pkg;

  // Fixed latency of group_add, from up_data sampled to dn_data holding the sum.
  // The valid-pipe length and the FIFO sizing check derive from it.
  localparam int GROUP_ADD_LATENCY = 5;

  // True when v is a positive power of two.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/group_add.sv
// Fixed-latency, handshake-free summing pipeline: adds the GROUP_NB numbers of
// a group modulo 2^NUM_WIDTH. Data is sampled every cycle; validity is tracked
// outside this block.
module group_add
  import group_add_ctrl_pkg::*;
#(
  parameter int GROUP_NB  = 3,
  parameter int NUM_WIDTH = 16
) (
  input  logic                          clk,
  input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
  output logic [NUM_WIDTH-1:0]          dn_data
);

  // Input register and adder register take two stages; the rest is delay.
  localparam int DLY = GROUP_ADD_LATENCY - 2;

  if (GROUP_NB != 3) begin : g_bad_group_nb
    $error("group_add supports GROUP_NB = 3 only");
  end
  if (DLY < 1) begin : g_bad_latency
    $error("group_add needs GROUP_ADD_LATENCY >= 3");
  end

  logic [NUM_WIDTH-1:0] num_q [GROUP_NB];
  logic [NUM_WIDTH-1:0] sum_d;
  logic [NUM_WIDTH-1:0] sum_q;
  logic [NUM_WIDTH-1:0] dly_q [DLY];

  // Three-way add; wraps naturally, which is the signed modulo result.
  always_comb begin
    sum_d = num_q[0] + num_q[1] + num_q[2];
  end

  // Datapath pipeline: capture inputs, register the sum, then delay it.
  // No reset here: contents are only meaningful when the caller marks them valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < GROUP_NB; i++) begin
      num_q[i] <= up_data[i*NUM_WIDTH +: NUM_WIDTH];
    end
    sum_q    <= sum_d;
    dly_q[0] <= sum_q;
    for (int k = 1; k < DLY; k++) begin
      dly_q[k] <= dly_q[k-1];
    end
  end

  assign dn_data = dly_q[DLY-1];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. Pointers carry one extra MSB so
// that equal low bits can be told apart as full or empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_d, wr_ptr_q;
  logic [AW:0]      rd_ptr_d, rd_ptr_q;

  // Next pointer values; each advances by one on its own strobe.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
  end

  // Pointer registers, cleared by reset (which empties the FIFO).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  // NOTE: the memory array is deliberately not reset; the pointers alone decide
  // which entries are live, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(wr_en && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_en && empty));

endmodule

// File: rtl/group_add_ctrl.sv
// Valid/ready wrapper around group_add. A valid shift register follows each
// accepted group through the fixed-latency pipeline, results land in a FWFT
// FIFO, and upstream is throttled by credits so backpressure never drops a sum.
module group_add_ctrl
  import group_add_ctrl_pkg::*;
#(
  parameter int GROUP_NB   = 3,
  parameter int NUM_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
  input  logic                          up_valid,
  output logic                          up_ready,
  output logic [NUM_WIDTH-1:0]          dn_data,
  output logic                          dn_valid,
  input  logic                          dn_ready,
  output logic [$clog2(FIFO_DEPTH):0]   dn_count
);

  localparam int LAT = GROUP_ADD_LATENCY;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int IW  = $clog2(LAT + 1);

  // The FIFO must absorb every group that can be in flight when the consumer stalls.
  if (FIFO_DEPTH < LAT) begin : g_bad_depth
    $error("FIFO_DEPTH must be >= GROUP_ADD_LATENCY");
  end
  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_pow2
    $error("FIFO_DEPTH must be a power of two");
  end

  logic                 up_fire;
  logic                 push;
  logic                 pop;
  logic [LAT-1:0]       vld_d, vld_q;
  logic [IW-1:0]        inflight_d, inflight_q;
  logic                 up_ready_d, up_ready_q;
  logic [CW-1:0]        next_count;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [NUM_WIDTH-1:0] sum;

  assign up_fire = up_valid & up_ready_q;
  assign push    = vld_q[LAT-1];
  assign pop     = dn_valid & dn_ready;

  group_add #(
    .GROUP_NB  (GROUP_NB),
    .NUM_WIDTH (NUM_WIDTH)
  ) u_group_add (
    .clk     (clk),
    .up_data (up_data),
    .dn_data (sum)
  );

  sync_fifo_fwft #(
    .WIDTH (NUM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (sum),
    .rd_en   (pop),
    .rd_data (dn_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Next-state for valid pipe, credit counter and registered ready.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    vld_d      = {vld_q[LAT-2:0], up_fire};
    inflight_d = inflight_q;
    next_count = fifo_count;
    if (up_fire && !push) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!up_fire && push) begin
      inflight_d = inflight_q - IW'(1);
    end
    if (push && !pop) begin
      next_count = fifo_count + CW'(1);
    end else if (!push && pop) begin
      next_count = fifo_count - CW'(1);
    end
    // Post-edge occupancy plus post-edge in-flight must leave room for one more.
    up_ready_d = !rst && ((int'(next_count) + int'(inflight_d)) < FIFO_DEPTH);
  end

  // Control state registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      inflight_q <= '0;
      up_ready_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      up_ready_q <= up_ready_d;
    end
  end

  assign up_ready = up_ready_q;
  assign dn_valid = !fifo_empty;
  assign dn_count = fifo_count;

  // The credit rule must make a push into a full FIFO impossible.
  a_credit_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_group_add_ctrl.sv
// Scoreboard bench for group_add_ctrl: expected sums are queued at each accept
// and compared in order at each output handshake.
module tb_group_add_ctrl;

  localparam int NW    = 16;
  localparam int NB    = 3;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NB*NW-1:0]     up_data = '0;
  logic                 up_valid = 1'b0;
  logic                 up_ready;
  logic [NW-1:0]        dn_data;
  logic                 dn_valid;
  logic                 dn_ready = 1'b0;
  logic [$clog2(DEPTH):0] dn_count;

  int n_checks = 0;
  int n_err    = 0;
  int n_acc    = 0;
  int n_out    = 0;
  logic [NW-1:0] exp_q [$];

  group_add_ctrl #(
    .GROUP_NB   (NB),
    .NUM_WIDTH  (NW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .up_data  (up_data),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .dn_data  (dn_data),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready),
    .dn_count (dn_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [NB*NW-1:0] grp(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                           input logic [NW-1:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [NW-1:0] model_sum(input logic [NB*NW-1:0] g);
    logic [NW-1:0] s;
    s = '0;
    for (int i = 0; i < NB; i++) s = s + g[i*NW +: NW];
    return s;
  endfunction

  // One cycle: drive at the falling edge, record the handshakes that the next
  // rising edge will perform, and compare any sum being taken.
  task automatic step(input logic uv, input logic [NB*NW-1:0] ud,
                      input logic [NW-1:0] exp_sum, input logic dr);
    logic [NW-1:0] e;
    @(negedge clk);
    up_valid = uv;
    up_data  = ud;
    dn_ready = dr;
    if (uv && up_ready) begin
      exp_q.push_back(exp_sum);
      n_acc++;
    end
    if (dn_valid && dr) begin
      n_out++;
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dn_data", 32'(dn_data), 32'(e));
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step(1'b0, '0, '0, 1'b1);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    step(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    int lat, acc0, out0;
    logic [NB*NW-1:0] g;
    logic [NW-1:0] a, b, c;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dn_valid", 32'(dn_valid), 32'd0);
    check("rst_dn_count", 32'(dn_count), 32'd0);
    check("rst_up_ready", 32'(up_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_up_ready", 32'(up_ready), 32'd1);

    // Single group {1,2,3}: output six cycles after the accept cycle
    step(1'b1, grp(16'd1, 16'd2, 16'd3), 16'd6, 1'b0);
    lat = 0;
    while (!dn_valid && lat < 20) begin
      step(1'b0, '0, '0, 1'b0);
      lat++;
    end
    check("single_latency", 32'(lat), 32'd6);
    check("single_data", 32'(dn_data), 32'd6);
    check("single_count", 32'(dn_count), 32'd1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    check("single_count_after_pop", 32'(dn_count), 32'd0);
    check("single_valid_after_pop", 32'(dn_valid), 32'd0);

    // Streaming: 20 back-to-back groups {i, 2i, -i}
    acc0 = n_acc;
    out0 = n_out;
    for (int i = 1; i <= 20; i++) begin
      check("stream_up_ready", 32'(up_ready), 32'd1);
      a = 16'(i);
      b = 16'(2 * i);
      c = 16'(-i);
      step(1'b1, grp(a, b, c), b, 1'b1);
    end
    repeat (6) step(1'b0, '0, '0, 1'b1);
    check("stream_accepts", 32'(n_acc - acc0), 32'd20);
    check("stream_outputs", 32'(n_out - out0), 32'd20);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: consumer stalled, producer always valid
    acc0 = n_acc;
    repeat (20) begin
      g = {16'($urandom), 16'($urandom), 16'($urandom)};
      step(1'b1, g, model_sum(g), 1'b0);
    end
    check("bp_accepts", 32'(n_acc - acc0), 32'd8);
    check("bp_up_ready", 32'(up_ready), 32'd0);
    check("bp_count", 32'(dn_count), 32'd8);
    acc0 = n_acc;
    repeat (30) begin
      g = {16'($urandom), 16'($urandom), 16'($urandom)};
      step(1'b1, g, model_sum(g), 1'b1);
    end
    check("bp_resume", 32'(n_acc - acc0 >= 20), 32'd1);
    drain();

    // Wrap-around arithmetic
    step(1'b1, grp(16'h7FFF, 16'h0001, 16'h0000), 16'h8000, 1'b1);
    step(1'b1, grp(16'h8000, 16'hFFFF, 16'h0000), 16'h7FFF, 1'b1);
    drain();

    // Reset mid-stream: two buffered, three in flight
    step(1'b1, grp(16'd10, 16'd0, 16'd0), 16'd10, 1'b0);
    step(1'b1, grp(16'd20, 16'd0, 16'd0), 16'd20, 1'b0);
    repeat (6) step(1'b0, '0, '0, 1'b0);
    check("mid_buffered", 32'(dn_count), 32'd2);
    step(1'b1, grp(16'd30, 16'd0, 16'd0), 16'd30, 1'b0);
    step(1'b1, grp(16'd40, 16'd0, 16'd0), 16'd40, 1'b0);
    step(1'b1, grp(16'd50, 16'd0, 16'd0), 16'd50, 1'b0);
    @(negedge clk);
    up_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_count", 32'(dn_count), 32'd0);
    check("mid_rst_valid", 32'(dn_valid), 32'd0);
    out0 = n_out;
    repeat (10) step(1'b0, '0, '0, 1'b1);
    check("mid_rst_quiet", 32'(n_out - out0), 32'd0);
    step(1'b1, grp(16'd5, 16'd6, 16'd7), 16'd18, 1'b1);
    drain();

    // Random soak
    repeat (600) begin
      g = {16'($urandom), 16'($urandom), 16'($urandom)};
      step(1'($urandom_range(0, 1)), g, model_sum(g), ($urandom_range(0, 3) != 0));
      check("soak_count_bound", 32'(dn_count <= DEPTH), 32'd1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
